// File: rtl/ex_csa_resolve_pkg.sv
// rtl/ex_csa_resolve_pkg.sv - shared types, defaults and helpers for the carry-save resolver
package ex_csa_pkg;

  // Resolver FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } csa_state_e;

  localparam int unsigned CSA_WIDTH_DEF = 64;
  localparam int unsigned CSA_CHUNK_DEF = 16;

  // Width of the chunk index counter; never narrower than one bit
  function automatic int unsigned csa_idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/ex_csa_resolve_chunk.sv
// rtl/ex_csa_resolve_chunk.sv - combinational CHUNK-bit adder with carry in/out
module ex_csa_resolve_chunk #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  // One extra bit of headroom captures the carry out of the chunk
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum   = total[CHUNK-1:0];
    cout  = total[CHUNK];
  end

endmodule

// File: rtl/ex_csa_resolve.sv
// rtl/ex_csa_resolve.sv - multi-cycle carry-save to binary resolver (optional flags: EX_CSA_RESOLVE_FLAGS_EN)
module ex_csa_resolve
  import ex_csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH_DEF,
  parameter int unsigned CHUNK = CSA_CHUNK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef EX_CSA_RESOLVE_FLAGS_EN
  output logic             out_cout,
  output logic             out_zero,
`endif
  output logic [WIDTH-1:0] out_res
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = csa_idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("ex_csa_resolve: WIDTH must be a multiple of CHUNK");
  end

  csa_state_e       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] qs_q, qs_d;
  logic [WIDTH-1:0] res_q, res_d;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
  logic             qtop_q, qtop_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
`else
  logic             unused_qtop;
  assign unused_qtop = in_q[WIDTH-1];
`endif

  logic [WIDTH-1:0] qs_in;
  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic             ch_cin, ch_cout;
  logic             done_accept;

  // Q[i] has weight 2^(i+1); the top bit falls off here and only feeds carry-out
  assign qs_in       = {in_q[WIDTH-2:0], 1'b0};
  assign done_accept = (state_q == ST_DONE) && out_ready && in_valid;

  // Adder operand mux: the current chunk of the held pair, or chunk 0 of a new pair
  // taken on the DONE handshake so back-to-back pairs need no bubble cycle
  always_comb begin
    ch_a   = p_q[idx_q*CHUNK +: CHUNK];
    ch_b   = qs_q[idx_q*CHUNK +: CHUNK];
    ch_cin = carry_q;
    if (done_accept) begin
      ch_a   = in_p[CHUNK-1:0];
      ch_b   = qs_in[CHUNK-1:0];
      ch_cin = 1'b0;
    end
  end

  ex_csa_resolve_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (ch_cin),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    p_d       = p_q;
    qs_d      = qs_q;
    res_d     = res_q;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
    qtop_d    = qtop_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          p_d     = in_p;
          qs_d    = qs_in;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ST_BUSY;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
          qtop_d  = in_q[WIDTH-1];
          cout_d  = 1'b0;
          zero_d  = 1'b1;
`endif
        end
      end

      ST_BUSY: begin
        res_d[idx_q*CHUNK +: CHUNK] = ch_sum;
        carry_d = ch_cout;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
        zero_d  = zero_q && (ch_sum == '0);
`endif
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
          cout_d  = ch_cout | qtop_q;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            p_d              = in_p;
            qs_d             = qs_in;
            res_d[CHUNK-1:0] = ch_sum;
            carry_d          = ch_cout;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
            qtop_d           = in_q[WIDTH-1];
            zero_d           = (ch_sum == '0);
`endif
            if (LAST_IDX == '0) begin
              state_d = ST_DONE;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
              cout_d  = ch_cout | in_q[WIDTH-1];
`endif
            end else begin
              idx_d   = IDXW'(1);
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any result in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      p_q     <= '0;
      qs_q    <= '0;
      res_q   <= '0;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
      qtop_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      qs_q    <= qs_d;
      res_q   <= res_d;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
      qtop_q  <= qtop_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign out_res  = res_q;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
  assign out_cout = cout_q;
  assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_ex_csa_resolve.sv
// tb/tb_ex_csa_resolve.sv - directed self-checking bench for ex_csa_resolve (flags checked with EX_CSA_RESOLVE_FLAGS_EN)
module tb_ex_csa_resolve;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_p;
  logic [63:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
`ifdef EX_CSA_RESOLVE_FLAGS_EN
  logic        out_cout;
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ex_csa_resolve #(
    .WIDTH (64),
    .CHUNK (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef EX_CSA_RESOLVE_FLAGS_EN
    .out_cout  (out_cout),
    .out_zero  (out_zero),
`endif
    .out_res   (out_res)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_pair(input string tag, input logic [63:0] p, input logic [63:0] q,
                          input logic [63:0] exp_res, input logic exp_cout,
                          input logic exp_zero, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, " in_ready"}, in_ready, 1);
    in_p     = p;
    in_q     = q;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_p     = ~p;
    in_q     = ~q;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, " latency"}, n, 4);
    check_eq({tag, " res"}, out_res, exp_res);
`ifdef EX_CSA_RESOLVE_FLAGS_EN
    check_eq({tag, " cout"}, out_cout, exp_cout);
    check_eq({tag, " zero"}, out_zero, exp_zero);
`else
    if (exp_cout && exp_zero) n = 0;
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, " hold valid"}, out_valid, 1);
      check_eq({tag, " hold res"}, out_res, exp_res);
      check_eq({tag, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, " valid drop"}, out_valid, 0);
  endtask

  logic [63:0] bp   [4];
  logic [63:0] bexp [4];

  initial begin
    int j;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_p      = '0;
    in_q      = '0;

    #12;
    check_eq("reset out_valid", out_valid, 0);
    check_eq("reset out_res", out_res, 0);
    step();
    reset = 1'b1;
    check_eq("post reset in_ready", in_ready, 1);

    run_pair("small", 64'h5, 64'h3, 64'hB, 1'b0, 1'b0, 10);
    run_pair("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1'b1, 1'b0, 0);
    run_pair("qtop", 64'h0, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 0);
    run_pair("chunk carry", 64'h8000, 64'h4000, 64'h1_0000, 1'b0, 1'b0, 0);
    run_pair("zero", 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 0);

    bp[0] = 64'h5;    bexp[0] = 64'hB;
    bp[1] = 64'h10;   bexp[1] = 64'h16;
    bp[2] = 64'hFFFF; bexp[2] = 64'h1_0005;
    bp[3] = 64'h7;    bexp[3] = 64'hD;
    j = 0;
    in_p      = bp[0];
    in_q      = 64'h3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      check_eq("b2b valid", out_valid, ((k % 4) == 0) ? 64'd1 : 64'd0);
      if ((k % 4) == 0) begin
        check_eq("b2b res", out_res, bexp[j]);
        j++;
        if (j < 4) in_p = bp[j];
        else in_valid = 1'b0;
      end
    end
    step();
    out_ready = 1'b0;
    check_eq("b2b end valid", out_valid, 0);
    check_eq("b2b end in_ready", in_ready, 1);

    in_p     = 64'h1111_2222_3333_4444;
    in_q     = 64'h0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("partial res", out_res, 64'h3333_4444);
    reset = 1'b0;
    #1;
    check_eq("mid reset valid", out_valid, 0);
    check_eq("mid reset res", out_res, 0);
    step();
    reset = 1'b1;
    run_pair("after reset", 64'h8000, 64'h4000, 64'h1_0000, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
